led_fade: RTL and testbench

- Brightness generator sitting directly upstream of the LED frequency limiter; its o_led drives the limiter's requested-level input.
- Accepts a target brightness over a valid/ready handshake and produces a strobe-paced PWM LED level.
- Moves either immediately (jump) or in a linear ramp of one step per RAMP_PERIODS PWM periods, for breathing and fade effects on the Fomu LED.
- All output changes are aligned to the shared 46.875 kHz strobe, so the downstream limiter never sees sub-strobe activity.

---
 rtl/led_fade_pkg.sv | 18 +
 rtl/led_pwm_core.sv | 40 ++++
 rtl/led_fade.sv | 129 ++++++++++++
 tb/tb_led_fade.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_fade_pkg.sv
// Shared constants and types for the Fomu LED brightness path.
// STB_FREQ_HZ  : rate of the shared single-cycle strobe feeding the PWM.
// PWM_BITS_DEF : default PWM resolution (period = 2^PWM_BITS strobes).
// LVL_FULL     : brightness value meaning "fully on" at the default resolution.
// fade_state_e : ramp controller states.
package led_fade_pkg;

  localparam int unsigned STB_FREQ_HZ  = 46_875;
  localparam int unsigned PWM_BITS_DEF = 4;
  localparam int unsigned LVL_FULL     = 2 ** PWM_BITS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_JUMP_PENDING
  } fade_state_e;

endpackage

// File: rtl/led_pwm_core.sv
// Strobe-paced PWM core: period counter, period-boundary detect, LED compare.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_stb          : single-cycle pacing strobe
//   i_lvl          : applied brightness, 0..2^PWM_BITS
//   o_bnd          : high in the strobe cycle where the counter wraps
//   o_led          : registered PWM output, changes only on strobes
module led_pwm_core
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stb,
  input  logic [PWM_BITS:0] i_lvl,
  output logic              o_bnd,
  output logic              o_led
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_nx;

  // Natural wrap from all-ones back to zero.
  assign cnt_nx = cnt_q + PWM_BITS'(1);
  assign o_bnd  = i_stb && (cnt_q == '1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      o_led <= 1'b0;
    end else if (i_stb) begin
      cnt_q <= cnt_nx;
      // Compare against the count being entered; a full-scale level is
      // larger than any count, so the LED stays solidly on.
      o_led <= ({1'b0, cnt_nx} < i_lvl);
    end
  end

endmodule

// File: rtl/led_fade.sv
// LED brightness generator with jump / linear-ramp transitions.
// A target brightness is accepted over valid/ready; the applied level
// moves only at PWM period boundaries, either at once (jump) or by one
// step every RAMP_PERIODS periods.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_stb          : shared pacing strobe
//   i_lvl          : requested brightness (values above full are clamped)
//   i_jump         : 1 = jump, 0 = ramp (qualified by i_valid)
//   i_valid        : request valid
//   o_ready        : request accepted this cycle if i_valid
//   o_busy         : applied level differs from target
//   o_lvl          : applied brightness
//   o_led          : PWM LED level
module led_fade
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS     = PWM_BITS_DEF,
  parameter int unsigned RAMP_PERIODS = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stb,
  input  logic [PWM_BITS:0] i_lvl,
  input  logic              i_jump,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_busy,
  output logic [PWM_BITS:0] o_lvl,
  output logic              o_led
);

  localparam int unsigned       LVL_W   = PWM_BITS + 1;
  localparam int unsigned       RC_W    = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PWM_BITS:0] FULL    = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [RC_W-1:0]   RC_LAST = RC_W'(RAMP_PERIODS - 1);

  fade_state_e       state_q, state_nx;
  logic [PWM_BITS:0] tgt_q, tgt_nx;
  logic [PWM_BITS:0] lvl_q, lvl_nx;
  logic              jump_q, jump_nx;
  logic [RC_W-1:0]   rc_q, rc_nx;
  logic              busy_q;
  logic              bnd;
  logic              accept;
  logic [PWM_BITS:0] req_lvl;

  assign o_ready = !busy_q;
  assign o_busy  = busy_q;
  assign o_lvl   = lvl_q;
  assign accept  = i_valid && !busy_q;
  assign req_lvl = (i_lvl > FULL) ? FULL : i_lvl;

  led_pwm_core #(
    .PWM_BITS (PWM_BITS)
  ) u_core (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_stb   (i_stb),
    .i_lvl   (lvl_q),
    .o_bnd   (bnd),
    .o_led   (o_led)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      lvl_q   <= '0;
      jump_q  <= 1'b0;
      rc_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      tgt_q   <= tgt_nx;
      lvl_q   <= lvl_nx;
      jump_q  <= jump_nx;
      rc_q    <= rc_nx;
      busy_q  <= (lvl_q != tgt_q);
    end
  end

  always_comb begin
    tgt_nx  = tgt_q;
    lvl_nx  = lvl_q;
    jump_nx = jump_q;
    rc_nx   = rc_q;

    // Boundary handling acts on the registered target/jump; an accept in
    // the same cycle is applied afterwards so it only counts from the next
    // boundary onward.
    if (bnd) begin
      case (state_q)
        ST_JUMP_PENDING: begin
          lvl_nx  = tgt_q;
          jump_nx = 1'b0;
          rc_nx   = '0;
        end
        ST_RAMP: begin
          if (rc_q == RC_LAST) begin
            rc_nx  = '0;
            lvl_nx = (lvl_q < tgt_q) ? lvl_q + LVL_W'(1) : lvl_q - LVL_W'(1);
          end else begin
            rc_nx = rc_q + RC_W'(1);
          end
        end
        default: begin
          // A jump to the current level still consumes its boundary.
          jump_nx = 1'b0;
          rc_nx   = '0;
        end
      endcase
    end

    if (accept) begin
      tgt_nx  = req_lvl;
      jump_nx = i_jump;
    end

    if (lvl_nx == tgt_nx) begin
      state_nx = ST_IDLE;
    end else if (jump_nx) begin
      state_nx = ST_JUMP_PENDING;
    end else begin
      state_nx = ST_RAMP;
    end
  end

endmodule

// File: tb/tb_led_fade.sv
module tb_led_fade;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic [4:0] lvl_in = '0;
  logic       jump = 1'b0;
  logic       valid = 1'b0;
  logic       ready, busy, led;
  logic [4:0] lvl;

  always #5 clk = ~clk;

  led_fade #(
    .PWM_BITS     (4),
    .RAMP_PERIODS (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_stb   (stb),
    .i_lvl   (lvl_in),
    .i_jump  (jump),
    .i_valid (valid),
    .o_ready (ready),
    .o_busy  (busy),
    .o_lvl   (lvl),
    .o_led   (led)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned ph      = 0;
  int unsigned tb_cnt  = 0;
  bit          bnd_seen = 1'b0;
  bit          last_s   = 1'b0;
  int          viol     = 0;

  typedef struct {
    int lvl;
    bit jmp;
    int exp_lvl;
  } vec_t;

  typedef struct {
    int lvl;
    int ones;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock: outputs are read 1 time unit after the edge, the bench's
  // own PWM position is advanced, and the next strobe value is driven.
  task automatic step();
    logic s, r, lp;
    s  = stb;
    r  = rst_n;
    lp = led;
    @(posedge clk);
    #1;
    last_s   = s;
    bnd_seen = r && s && (tb_cnt == 15);
    if (!r) tb_cnt = 0;
    else if (s) tb_cnt = (tb_cnt + 1) % 16;
    if (r && !s && (led !== lp)) viol++;
    ph++;
    stb = (ph % 4 == 0);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else step();
    end
    if (!ok) check({name, " idle timeout"}, 0, 1);
  endtask

  task automatic send(input int l, input bit j);
    wait_idle("send");
    valid  = 1'b1;
    lvl_in = 5'(l);
    jump   = j;
    step();
    valid = 1'b0;
    step();
  endtask

  task automatic count_ones(input int nstb, output int ones);
    int seen = 0;
    ones = 0;
    for (int i = 0; i < nstb * 4 + 16 && seen < nstb; i++) begin
      step();
      if (last_s) begin
        seen++;
        if (led) ones++;
      end
    end
    if (seen < nstb) check("strobe count timeout", seen, nstb);
  endtask

  initial begin
    int   ones, nb, peak;
    bit   got, pre_ok, ok;
    exp_t e;

    vecs[0] = '{20, 1'b1, 16};
    vecs[1] = '{0,  1'b1, 0};
    vecs[2] = '{3,  1'b0, 3};
    vecs[3] = '{3,  1'b1, 3};
    vecs[4] = '{12, 1'b0, 12};
    vecs[5] = '{31, 1'b0, 16};
    vecs[6] = '{9,  1'b1, 9};
    vecs[7] = '{7,  1'b0, 7};

    // Reset state and quiet LED.
    rst_n = 1'b0;
    repeat (3) step();
    check("reset led", led, 0);
    check("reset lvl", lvl, 0);
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    rst_n = 1'b1;
    count_ones(100, ones);
    check("idle led ones over 100 strobes", ones, 0);

    // Ramp 0 -> 3: one step every second boundary.
    valid = 1'b1; lvl_in = 5'd3; jump = 1'b0;
    step();
    valid = 1'b0;
    nb = 0;
    for (int i = 0; i < 1000 && nb < 6; i++) begin
      step();
      if (i == 0) begin
        check("ramp busy after accept", busy, 1);
        check("ramp ready after accept", ready, 0);
      end
      if (bnd_seen) begin
        nb++;
        check($sformatf("ramp lvl at boundary %0d", nb), lvl, nb / 2);
      end
    end
    check("ramp ready when lvl reaches 3", ready, 0);
    step();
    check("ramp ready next cycle", ready, 1);
    check("ramp busy next cycle", busy, 0);

    // Jump 3 -> 8, applied at the next boundary only.
    valid = 1'b1; lvl_in = 5'd8; jump = 1'b1;
    step();
    valid = 1'b0;
    got = 1'b0; pre_ok = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (i == 0) begin
        check("jump busy after accept", busy, 1);
        check("jump ready after accept", ready, 0);
      end
      if (bnd_seen) got = 1'b1;
      else if (lvl != 3) pre_ok = 1'b0;
    end
    check("jump lvl held before boundary", int'(pre_ok), 1);
    check("jump lvl after boundary", lvl, 8);
    count_ones(16, ones);
    check("jump duty 8", ones, 8);

    // Table of jumps and ramps through the scoreboard.
    foreach (vecs[k]) begin
      send(vecs[k].lvl, vecs[k].jmp);
      sb.push_back('{vecs[k].exp_lvl, vecs[k].exp_lvl});
      wait_idle($sformatf("vec %0d", k));
      e = sb.pop_front();
      check($sformatf("vec %0d final lvl", k), lvl, e.lvl);
      count_ones(16, ones);
      check($sformatf("vec %0d duty", k), ones, e.ones);
    end

    // Request held while busy: must wait for the ramp 7 -> 10 to finish.
    send(10, 1'b0);
    valid = 1'b1; lvl_in = 5'd5; jump = 1'b0;
    peak = lvl;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else begin
        step();
        if (lvl > peak) peak = lvl;
      end
    end
    check("held request: lvl when busy falls", lvl, 10);
    step();
    valid = 1'b0;
    step();
    check("held request: busy after accept", busy, 1);
    wait_idle("held request");
    check("held request: peak lvl", peak, 10);
    check("held request: final lvl", lvl, 5);

    // Accept in the same cycle as a boundary: takes effect one period later.
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (stb && tb_cnt == 15) got = 1'b1;
      else step();
    end
    if (!got) check("boundary alignment timeout", 0, 1);
    valid = 1'b1; lvl_in = 5'd12; jump = 1'b1;
    step();
    valid = 1'b0;
    check("coincident accept: lvl unchanged", lvl, 5);
    got = 1'b0; pre_ok = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (bnd_seen) got = 1'b1;
      else if (lvl != 5) pre_ok = 1'b0;
    end
    check("coincident accept: held for a period", int'(pre_ok), 1);
    check("coincident accept: lvl after next boundary", lvl, 12);

    // Reset in the middle of a ramp 0 -> 6.
    send(0, 1'b1);
    wait_idle("to zero");
    check("back to zero", lvl, 0);
    send(6, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (lvl == 2) ok = 1'b1;
      else step();
    end
    check("mid-ramp reached 2", int'(ok), 1);
    rst_n = 1'b0;
    step();
    check("mid-ramp reset led", led, 0);
    check("mid-ramp reset lvl", lvl, 0);
    check("mid-ramp reset busy", busy, 0);
    check("mid-ramp reset ready", ready, 1);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (lvl != 0 || busy) ok = 1'b0;
    end
    check("no resume after reset", int'(ok), 1);

    check("led edges outside strobe cycles", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
